pipelined_ripple_adder: RTL

//  N-bit add/subtract unit built from ripple-adder chunks, with pipeline registers between chunks.

---
 rtl/pipelined_ripple_adder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
// N-bit add/subtract unit whose carry chain is cut into STAGES registered
// segments. Each segment sums one CHUNK-bit slice with a small ripple chain
// and hands its carry to the next segment one cycle later. Upper operand
// slices travel down the pipe alongside the work (input skew), and sum
// slices that are already finished travel with them (output deskew), so
// the last segment presents a complete, aligned result.
//
// Flow control is a single global advance: the whole pipe moves when the
// output slot is empty or being drained, and freezes otherwise. Empty slots
// move like data, so latency is always exactly STAGES cycles when the
// consumer keeps out_ready high.

module pipelined_ripple_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         co,
  output logic         ov
);

  localparam int CHUNK = N / STAGES;
  localparam int LAST  = STAGES - 1;

  // Configuration guard: every segment must own an equal slice of the word.
  if ((STAGES < 1) || ((N % STAGES) != 0)) begin : g_cfg_check
    $error("pipelined_ripple_adder: N must be a positive multiple of STAGES");
  end

  // ---------------------------------------------------------------------------
  // CHUNK-bit ripple chain.
  // Returns {carry into the chunk MSB, carry out of the chunk, chunk sum}.
  // The carry into the MSB is only meaningful for the top chunk, where it
  // feeds the signed-overflow flag.
  // ---------------------------------------------------------------------------
  function automatic logic [CHUNK+1:0] ripple_chunk(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             cin
  );
    logic [CHUNK-1:0] sum;
    logic             carry;
    logic             carry_msb;
    sum       = {CHUNK{1'b0}};
    carry     = cin;
    carry_msb = cin;
    for (int i = 0; i < CHUNK; i++) begin
      carry_msb = carry;
      sum[i]    = a[i] ^ b[i] ^ carry;
      carry     = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    return {carry_msb, carry, sum};
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state. Index k holds the result of segment k.
  //   vld_r : slot carries a real beat
  //   a_r   : operand A, travelling toward the segment that needs its slice
  //   b_r   : operand B after the subtract inversion
  //   s_r   : sum slices 0..k complete, higher slices not yet meaningful
  //   c_r   : carry out of slice k
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] vld_r;
  logic [N-1:0]      a_r [STAGES];
  logic [N-1:0]      b_r [STAGES];
  logic [N-1:0]      s_r [STAGES];
  logic [STAGES-1:0] c_r;
  logic              ov_r;

  // Per-segment combinational view: what each segment sees and produces.
  logic [STAGES-1:0] v_src_s;
  logic [N-1:0]      a_src_s [STAGES];
  logic [N-1:0]      b_src_s [STAGES];
  logic [N-1:0]      s_src_s [STAGES];
  logic [STAGES-1:0] c_src_s;
  logic [CHUNK+1:0]  rc_s    [STAGES];
  logic [N-1:0]      s_nxt_s [STAGES];
  logic              ov_nxt_s;

  logic adv_s;
  logic fire_s;

  // The pipe moves whenever the output slot is free or is being consumed;
  // in_ready therefore depends combinationally on out_ready.
  assign adv_s    = ~vld_r[LAST] | out_ready;
  assign in_ready = adv_s;
  assign fire_s   = in_valid & adv_s;

  // Segment datapath: choose each segment's sources, run its ripple slice
  // and merge the new slice into the sum word it passes on.
  always_comb begin
    // Segment 0 takes operands straight from the ports. Subtraction is
    // A + ~B + 1 with the borrow-in folded into the carry-in.
    v_src_s[0] = in_valid;
    a_src_s[0] = A;
    b_src_s[0] = sub ? ~B : B;
    c_src_s[0] = ci ^ sub;
    s_src_s[0] = {N{1'b0}};

    // Later segments take everything from the register of the segment before.
    for (int k = 1; k < STAGES; k++) begin
      v_src_s[k] = vld_r[k-1];
      a_src_s[k] = a_r[k-1];
      b_src_s[k] = b_r[k-1];
      c_src_s[k] = c_r[k-1];
      s_src_s[k] = s_r[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      rc_s[k]    = ripple_chunk(a_src_s[k][k*CHUNK +: CHUNK],
                                b_src_s[k][k*CHUNK +: CHUNK],
                                c_src_s[k]);
      s_nxt_s[k] = s_src_s[k];
      s_nxt_s[k][k*CHUNK +: CHUNK] = rc_s[k][CHUNK-1:0];
    end

    // Signed overflow: carry into bit N-1 differs from carry out of bit N-1.
    ov_nxt_s = rc_s[LAST][CHUNK+1] ^ rc_s[LAST][CHUNK];
  end

  // Segment registers: cleared by reset, all move together on advance and
  // all hold otherwise. Segment 0 captures operands only on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {STAGES{1'b0}};
      c_r   <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= {N{1'b0}};
        b_r[k] <= {N{1'b0}};
        s_r[k] <= {N{1'b0}};
      end
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= v_src_s[k];
        if ((k > 0) || fire_s) begin
          a_r[k] <= a_src_s[k];
          b_r[k] <= b_src_s[k];
          s_r[k] <= s_nxt_s[k];
          c_r[k] <= rc_s[k][CHUNK];
        end
      end
    end
  end

  // Overflow flag register, loaded alongside the final segment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_r <= 1'b0;
    end else if (adv_s && ((LAST > 0) || fire_s)) begin
      ov_r <= ov_nxt_s;
    end
  end

  assign out_valid = vld_r[LAST];
  assign S         = s_r[LAST];
  assign co        = c_r[LAST];
  assign ov        = ov_r;

endmodule
